// File: rtl/sobel_sched_pkg.sv
// Shared types and width helpers for the Sobel frame scheduler.
// Widths that depend on frame geometry are derived in each module through these helpers.
package sobel_sched_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StFetchReq,
    StFetchWait,
    StDrain,
    StGap,
    StDone
  } sched_state_e;

  localparam int unsigned DefaultImgWidth  = 8;
  localparam int unsigned DefaultImgHeight = 8;
  localparam int unsigned DefaultGapCycles = 2;

  // Bits needed to hold every value in 0..max_val (never less than one bit).
  function automatic int unsigned cnt_bits(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

  // Width of the destination frame: a 3x3 window loses one column on each side.
  function automatic int unsigned out_width(input int unsigned img_width);
    return img_width - 2;
  endfunction

endpackage

// File: rtl/sobel_addr_gen.sv
// Strip/row/column walker for the Sobel scheduler: produces the source read address
// and flags for the last pixel of a strip and the last strip of a frame.
module sobel_addr_gen
  import sobel_sched_pkg::*;
#(
  parameter int unsigned IMG_WIDTH  = DefaultImgWidth,
  parameter int unsigned IMG_HEIGHT = DefaultImgHeight,
  parameter int unsigned ADDR_BITS  = 16,
  parameter int unsigned XS_BITS    = cnt_bits(IMG_WIDTH - 3)
) (
  input  logic                 clk_i,
  input  logic                 nreset_i,
  input  logic                 clear_i,
  input  logic                 step_i,
  input  logic                 next_strip_i,
  output logic [XS_BITS-1:0]   xs_o,
  output logic [ADDR_BITS-1:0] addr_o,
  output logic                 strip_last_o,
  output logic                 frame_last_o
);

  localparam int unsigned Y_BITS = cnt_bits(IMG_HEIGHT - 1);

  logic [XS_BITS-1:0] xs_q;
  logic [Y_BITS-1:0]  y_q;
  logic [1:0]         c_q;
  logic               y_last;

  assign y_last = (y_q == Y_BITS'(IMG_HEIGHT - 1));

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      xs_q <= '0;
      y_q  <= '0;
      c_q  <= '0;
    end else if (clear_i) begin
      xs_q <= '0;
      y_q  <= '0;
      c_q  <= '0;
    end else if (next_strip_i) begin
      xs_q <= xs_q + 1'b1;
      y_q  <= '0;
      c_q  <= '0;
    end else if (step_i) begin
      // Row-major inside the strip: three columns, then the next row.
      if (c_q == 2'd2) begin
        c_q <= '0;
        y_q <= y_last ? '0 : y_q + 1'b1;
      end else begin
        c_q <= c_q + 1'b1;
      end
    end
  end

  assign xs_o         = xs_q;
  assign strip_last_o = y_last && (c_q == 2'd2);
  assign frame_last_o = (xs_q == XS_BITS'(IMG_WIDTH - 3));
  assign addr_o       = ADDR_BITS'(y_q) * ADDR_BITS'(IMG_WIDTH) + ADDR_BITS'(xs_q)
                      + ADDR_BITS'(c_q);

endmodule

// File: rtl/sobel_frame_scheduler.sv
// Frame sequencer for the 3x3 Sobel window unit: fetches 3-wide strips pixel by pixel,
// streams them to the window unit and writes each gradient result to the output frame.
module sobel_frame_scheduler
  import sobel_sched_pkg::*;
#(
  parameter int unsigned IMG_WIDTH       = DefaultImgWidth,
  parameter int unsigned IMG_HEIGHT      = DefaultImgHeight,
  parameter int unsigned PIXEL_WIDTH_OUT = 8,
  parameter int unsigned ADDR_BITS       = 16,
  parameter int unsigned GAP_CYCLES      = DefaultGapCycles
) (
  input  logic                       clk_i,
  input  logic                       nreset_i,
  input  logic                       start_i,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       err_o,
  output logic                       rd_req_o,
  output logic [ADDR_BITS-1:0]       rd_addr_o,
  input  logic [PIXEL_WIDTH_OUT-1:0] rd_data_i,
  input  logic                       rd_valid_i,
  output logic                       start_sobel_o,
  output logic [PIXEL_WIDTH_OUT-1:0] px_o,
  output logic                       px_rdy_o,
  input  logic [PIXEL_WIDTH_OUT-1:0] sobel_px_i,
  input  logic                       sobel_rdy_i,
  output logic                       wr_en_o,
  output logic [ADDR_BITS-1:0]       wr_addr_o,
  output logic [PIXEL_WIDTH_OUT-1:0] wr_data_o
);

  localparam int unsigned XS_BITS  = cnt_bits(IMG_WIDTH - 3);
  localparam int unsigned RO_BITS  = cnt_bits(IMG_HEIGHT - 2);
  localparam int unsigned GAP_BITS = cnt_bits(GAP_CYCLES - 1);
  localparam int unsigned OUT_W    = out_width(IMG_WIDTH);

  sched_state_e state_q, state_d;

  logic                       start_sobel_q, start_sobel_d;
  logic                       err_q, err_d;
  logic [PIXEL_WIDTH_OUT-1:0] px_q, px_d;
  logic                       px_rdy_q, px_rdy_d;
  logic                       wr_en_q, wr_en_d;
  logic [ADDR_BITS-1:0]       wr_addr_q, wr_addr_d;
  logic [PIXEL_WIDTH_OUT-1:0] wr_data_q, wr_data_d;
  logic [RO_BITS-1:0]         ro_q, ro_d;
  logic [GAP_BITS-1:0]        gap_q, gap_d;

  logic                 ctr_clear, ctr_step, ctr_next_strip;
  logic [XS_BITS-1:0]   xs;
  logic [ADDR_BITS-1:0] src_addr;
  logic                 strip_last, frame_last;
  logic                 ro_full;

  sobel_addr_gen #(
    .IMG_WIDTH  (IMG_WIDTH),
    .IMG_HEIGHT (IMG_HEIGHT),
    .ADDR_BITS  (ADDR_BITS),
    .XS_BITS    (XS_BITS)
  ) u_addr_gen (
    .clk_i        (clk_i),
    .nreset_i     (nreset_i),
    .clear_i      (ctr_clear),
    .step_i       (ctr_step),
    .next_strip_i (ctr_next_strip),
    .xs_o         (xs),
    .addr_o       (src_addr),
    .strip_last_o (strip_last),
    .frame_last_o (frame_last)
  );

  assign ro_full = (ro_q == RO_BITS'(IMG_HEIGHT - 2));

  always_comb begin
    state_d        = state_q;
    start_sobel_d  = start_sobel_q;
    err_d          = err_q;
    px_d           = px_q;
    px_rdy_d       = 1'b0;
    wr_en_d        = 1'b0;
    wr_addr_d      = wr_addr_q;
    wr_data_d      = wr_data_q;
    ro_d           = ro_q;
    gap_d          = gap_q;
    ctr_clear      = 1'b0;
    ctr_step       = 1'b0;
    ctr_next_strip = 1'b0;

    // Result capture is independent of the fetch side and runs in every busy state.
    if (state_q != StIdle && sobel_rdy_i) begin
      if (!ro_full) begin
        wr_en_d   = 1'b1;
        wr_data_d = sobel_px_i;
        wr_addr_d = ADDR_BITS'(ro_q) * ADDR_BITS'(OUT_W) + ADDR_BITS'(xs);
        ro_d      = ro_q + 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d       = StFetchReq;
          start_sobel_d = 1'b1;
          err_d         = 1'b0;
          ctr_clear     = 1'b1;
          ro_d          = '0;
        end else if (sobel_rdy_i) begin
          err_d = 1'b1;
        end
      end
      StFetchReq: begin
        state_d = StFetchWait;
      end
      StFetchWait: begin
        if (rd_valid_i) begin
          px_d     = rd_data_i;
          px_rdy_d = 1'b1;
          ctr_step = 1'b1;
          state_d  = strip_last ? StDrain : StFetchReq;
        end
      end
      StDrain: begin
        if (ro_full) begin
          start_sobel_d = 1'b0;
          gap_d         = '0;
          state_d       = StGap;
        end
      end
      StGap: begin
        if (gap_q == GAP_BITS'(GAP_CYCLES - 1)) begin
          if (frame_last) begin
            state_d = StDone;
          end else begin
            ctr_next_strip = 1'b1;
            ro_d           = '0;
            start_sobel_d  = 1'b1;
            state_d        = StFetchReq;
          end
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      state_q       <= StIdle;
      start_sobel_q <= 1'b0;
      err_q         <= 1'b0;
      px_q          <= '0;
      px_rdy_q      <= 1'b0;
      wr_en_q       <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      ro_q          <= '0;
      gap_q         <= '0;
    end else begin
      state_q       <= state_d;
      start_sobel_q <= start_sobel_d;
      err_q         <= err_d;
      px_q          <= px_d;
      px_rdy_q      <= px_rdy_d;
      wr_en_q       <= wr_en_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
      ro_q          <= ro_d;
      gap_q         <= gap_d;
    end
  end

  // The request stays high across back-to-back fetches; each accepted rd_valid_i ends one read.
  assign rd_req_o      = (state_q == StFetchReq) || (state_q == StFetchWait);
  assign rd_addr_o     = rd_req_o ? src_addr : '0;
  assign busy_o        = (state_q != StIdle);
  assign done_o        = (state_q == StDone);
  assign err_o         = err_q;
  assign start_sobel_o = start_sobel_q;
  assign px_o          = px_q;
  assign px_rdy_o      = px_rdy_q;
  assign wr_en_o       = wr_en_q;
  assign wr_addr_o     = wr_addr_q;
  assign wr_data_o     = wr_data_q;

endmodule

// File: tb/tb_sobel_frame_scheduler.sv
// Randomized directed bench: source memory and window unit models plus a frame-level
// reference computed straight from the stored image.
module tb_sobel_frame_scheduler;

  localparam int W     = 5;
  localparam int H     = 4;
  localparam int GAP   = 2;
  localparam int NREAD = (W - 2) * H * 3;
  localparam int NWR   = (W - 2) * (H - 2);

  logic        clk = 1'b0;
  logic        nreset = 1'b0;
  logic        start = 1'b0;
  logic        busy_o, done_o, err_o, rd_req_o, start_sobel_o, px_rdy_o, wr_en_o;
  logic [15:0] rd_addr_o, wr_addr_o;
  logic [7:0]  px_o, wr_data_o;
  logic [7:0]  rd_data = '0;
  logic        rd_valid = 1'b0;
  logic [7:0]  sobel_px = '0;
  logic        sobel_rdy = 1'b0;

  sobel_frame_scheduler #(
    .IMG_WIDTH       (W),
    .IMG_HEIGHT      (H),
    .PIXEL_WIDTH_OUT (8),
    .ADDR_BITS       (16),
    .GAP_CYCLES      (GAP)
  ) dut (
    .clk_i         (clk),
    .nreset_i      (nreset),
    .start_i       (start),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .err_o         (err_o),
    .rd_req_o      (rd_req_o),
    .rd_addr_o     (rd_addr_o),
    .rd_data_i     (rd_data),
    .rd_valid_i    (rd_valid),
    .start_sobel_o (start_sobel_o),
    .px_o          (px_o),
    .px_rdy_o      (px_rdy_o),
    .sobel_px_i    (sobel_px),
    .sobel_rdy_i   (sobel_rdy),
    .wr_en_o       (wr_en_o),
    .wr_addr_o     (wr_addr_o),
    .wr_data_o     (wr_data_o)
  );

  always #5 clk = ~clk;

  logic [7:0] img [W*H];
  int rd_log[$];
  int wr_a[$];
  int wr_d[$];
  int gap_runs[$];
  int fall_wr[$];
  int win[$];
  int res_v[$];
  int res_t[$];
  int px_cnt = 0, done_cnt = 0, done_base = 0, req_drop = 0, addr_unstable = 0;
  int lat_lo = 1, lat_hi = 1, cnt = 0, req_addr = 0, cyc = 0, spur_req = 0;
  int low_cnt = 0, s = 0;
  bit pending = 0, prev_ss = 0, in_gap = 0;
  int n_cmp = 0, n_bad = 0;

  // Source memory, window unit and output monitors, all sampled on the falling edge.
  always @(negedge clk) begin
    if (!nreset) begin
      rd_valid = 1'b0;
      pending  = 0;
      sobel_rdy = 1'b0;
      win.delete();
      res_v.delete();
      res_t.delete();
      prev_ss = 0;
      in_gap  = 0;
    end else begin
      cyc++;
      if (rd_valid) begin
        rd_valid = 1'b0;
        pending  = 0;
      end else if (pending) begin
        if (!rd_req_o) req_drop++;
        if (int'(rd_addr_o) != req_addr) addr_unstable++;
        cnt--;
        if (cnt <= 0) begin
          rd_valid = 1'b1;
          rd_data  = img[req_addr];
        end
      end
      if (!pending && rd_req_o) begin
        pending  = 1;
        cnt      = int'($urandom_range(lat_hi, lat_lo));
        req_addr = int'(rd_addr_o);
        rd_log.push_back(req_addr);
      end

      if (!start_sobel_o) win.delete();
      if (px_rdy_o) begin
        px_cnt++;
        win.push_back(int'(px_o));
        if (win.size() >= 9 && win.size() % 3 == 0) begin
          s = 0;
          for (int i = win.size() - 9; i < win.size(); i++) s += win[i];
          res_v.push_back(s & 255);
          res_t.push_back(cyc + 2);
        end
      end
      sobel_rdy = 1'b0;
      if (res_t.size() > 0 && res_t[0] <= cyc) begin
        sobel_rdy = 1'b1;
        sobel_px  = 8'(res_v.pop_front());
        void'(res_t.pop_front());
      end else if (spur_req > 0) begin
        sobel_rdy = 1'b1;
        sobel_px  = 8'hEE;
        spur_req--;
      end

      if (wr_en_o) begin
        wr_a.push_back(int'(wr_addr_o));
        wr_d.push_back(int'(wr_data_o));
      end
      if (prev_ss && !start_sobel_o) begin
        in_gap  = 1;
        low_cnt = 0;
        fall_wr.push_back(wr_a.size());
      end
      if (in_gap && !start_sobel_o) low_cnt++;
      if (!prev_ss && start_sobel_o && in_gap) begin
        gap_runs.push_back(low_cnt);
        in_gap = 0;
      end
      if (done_o) begin
        done_cnt++;
        in_gap = 0;
      end
      prev_ss = start_sobel_o;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic prep_frame(input int lo, input int hi);
    rd_log.delete();
    wr_a.delete();
    wr_d.delete();
    gap_runs.delete();
    fall_wr.delete();
    px_cnt = 0;
    req_drop = 0;
    addr_unstable = 0;
    lat_lo = lo;
    lat_hi = hi;
    for (int i = 0; i < W * H; i++) img[i] = 8'($urandom);
    done_base = done_cnt;
  endtask

  task automatic kick();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    @(negedge clk);
    while (done_o !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done_seen"}, done_o, 1);
  endtask

  // Expected reads and writes derived directly from the stored frame.
  task automatic check_frame(input string tag, input int exp_err);
    int k;
    int sum;
    repeat (3) @(negedge clk);
    check({tag, "_rd_count"}, rd_log.size(), NREAD);
    if (rd_log.size() == NREAD) begin
      k = 0;
      for (int xs = 0; xs < W - 2; xs++)
        for (int y = 0; y < H; y++)
          for (int c = 0; c < 3; c++) begin
            check({tag, "_rd_addr"}, rd_log[k], y * W + xs + c);
            k++;
          end
    end
    check({tag, "_px_count"}, px_cnt, NREAD);
    check({tag, "_wr_count"}, wr_a.size(), NWR);
    if (wr_a.size() == NWR) begin
      k = 0;
      for (int xs = 0; xs < W - 2; xs++)
        for (int yo = 0; yo < H - 2; yo++) begin
          sum = 0;
          for (int dy = 0; dy < 3; dy++)
            for (int dx = 0; dx < 3; dx++) sum += int'(img[(yo + dy) * W + xs + dx]);
          check({tag, "_wr_addr"}, wr_a[k], yo * (W - 2) + xs);
          check({tag, "_wr_data"}, wr_d[k], sum & 255);
          k++;
        end
    end
    check({tag, "_done_pulses"}, done_cnt - done_base, 1);
    check({tag, "_err"}, err_o, exp_err);
    check({tag, "_busy_after"}, busy_o, 0);
    check({tag, "_req_dropped"}, req_drop, 0);
    check({tag, "_addr_unstable"}, addr_unstable, 0);
  endtask

  initial begin
    int n;
    #1;
    check("rst_ctl", {busy_o, done_o, err_o, rd_req_o, start_sobel_o, px_rdy_o, wr_en_o}, 0);
    check("rst_addr", {rd_addr_o, wr_addr_o}, 0);
    check("rst_data", {px_o, wr_data_o}, 0);
    @(negedge clk);
    nreset = 1'b1;
    @(negedge clk);

    // Single-cycle read latency, full frame.
    prep_frame(1, 1);
    kick();
    check("s1_busy_on_start", busy_o, 1);
    check("s1_start_sobel", start_sobel_o, 1);
    wait_done("s1");
    check_frame("s1", 0);

    // Random read latency; strip gap length and placement.
    prep_frame(1, 7);
    kick();
    wait_done("s2");
    check_frame("s2", 0);
    check("s3_gap_count", gap_runs.size(), W - 3);
    for (int i = 0; i < gap_runs.size(); i++) check("s3_gap_len", gap_runs[i], GAP);
    check("s3_fall_count", fall_wr.size(), W - 2);
    for (int i = 0; i < fall_wr.size(); i++) check("s3_fall_after_wr", fall_wr[i], (i + 1) * (H - 2));

    // Spurious result while idle, then an extra result inside a strip.
    @(negedge clk);
    spur_req = 1;
    repeat (4) @(negedge clk);
    check("s4_idle_err", err_o, 1);
    check("s4_idle_no_wr", wr_a.size(), NWR);
    prep_frame(1, 3);
    kick();
    check("s4_err_cleared", err_o, 0);
    n = 0;
    while (!(busy_o && !start_sobel_o) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("s4_reached_gap", busy_o && !start_sobel_o, 1);
    spur_req = 1;
    wait_done("s4");
    check_frame("s4", 1);
    prep_frame(1, 2);
    kick();
    check("s4_err_clear_restart", err_o, 0);
    wait_done("s4b");
    check_frame("s4b", 0);

    // Asynchronous reset in strip 2 while a read is outstanding.
    prep_frame(5, 5);
    kick();
    n = 0;
    while (rd_log.size() < 16 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check("s5_in_fetch_wait", rd_req_o, 1);
    check("s5_strip2_addr", rd_addr_o, 6);
    #2;
    nreset = 1'b0;
    #1;
    check("s5_rst_ctl", {busy_o, done_o, err_o, rd_req_o, start_sobel_o, px_rdy_o, wr_en_o}, 0);
    check("s5_rst_addr", {rd_addr_o, wr_addr_o}, 0);
    check("s5_rst_data", {px_o, wr_data_o}, 0);
    repeat (2) @(negedge clk);
    nreset = 1'b1;
    @(negedge clk);
    prep_frame(1, 4);
    kick();
    wait_done("s5");
    check_frame("s5", 0);

    // start_i held through a frame, then pulsed while busy.
    prep_frame(1, 2);
    @(negedge clk);
    start = 1'b1;
    wait_done("s6a");
    check("s6_one_frame_reads", rd_log.size(), NREAD);
    check("s6_busy_in_done", busy_o, 1);
    @(negedge clk);
    check("s6_idle_reentered", busy_o, 0);
    @(negedge clk);
    check("s6_second_start", busy_o, 1);
    start = 1'b0;
    repeat (10) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("s6b");
    repeat (3) @(negedge clk);
    check("s6_no_third_frame", busy_o, 0);
    check("s6_total_reads", rd_log.size(), 2 * NREAD);
    check("s6_total_writes", wr_a.size(), 2 * NWR);
    check("s6_done_pulses", done_cnt - done_base, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
